// File: rtl/p1_dir_ctrl_if.sv
// Player-1 input/output bundle between the scan/button sources and p1_dir_ctrl.
// master drives scan position, buttons and crash; slave returns direction code and strobes.
interface p1_dir_ctrl_if;
  logic [9:0] row;
  logic [9:0] col;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_start;
  logic       crash;
  logic [3:0] p1_info;
  logic       dflt;
  logic       frame_tick;

  modport master (
    output row, col, btn_up, btn_down, btn_left, btn_right, btn_start, crash,
    input  p1_info, dflt, frame_tick
  );

  modport slave (
    input  row, col, btn_up, btn_down, btn_left, btn_right, btn_start, crash,
    output p1_info, dflt, frame_tick
  );
endinterface

// File: rtl/p1_dir_ctrl.sv
// Player-1 button conditioning, frame-aligned direction latch and game-state FSM.
// Build option: define REVERSE_LOCK_EN to discard 180-degree reversals at the frame boundary.
module p1_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int FRAME_ROW       = 599,
  parameter int FRAME_COL       = 799
) (
  input logic          clock,
  input logic          reset,
  p1_dir_ctrl_if.slave bus
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_STOPPED = 2'd2;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;
  localparam logic [3:0] CODE_STOP = 4'b1001;
  localparam logic [3:0] CODE_HOLD = 4'b0000;

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEBOUNCE_CYCLES - 1);

  // One-hot direction codes map to their opposite by swapping the bit pairs.
  function automatic logic [3:0] opposite_dir(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  logic [4:0]       raw_s;
  logic [4:0]       sync1_r, sync2_r, deb_r, deb_d_r;
  logic [CNT_W-1:0] cnt_r [5];
  logic [4:0]       press_s;
  logic             dir_press_s, start_press_s, bnd_s, apply_s;
  logic [3:0]       press_dir_s, next_dir_s;
  logic             pend_vld_r, start_req_r, dflt_r, frame_tick_r;
  logic [3:0]       pend_dir_r, cur_dir_r, p1_info_r;
  logic [1:0]       state_r;

  assign raw_s         = {bus.btn_start, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
  assign press_s       = deb_r & ~deb_d_r;
  assign dir_press_s   = |press_s[3:0];
  assign start_press_s = press_s[4];
  assign bnd_s         = (bus.row == 10'(FRAME_ROW)) && (bus.col == 10'(FRAME_COL));

  // Two-flop synchronisers, per-button debounce counters and press edge history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 5'b00000;
      sync2_r <= 5'b00000;
      deb_r   <= 5'b00000;
      deb_d_r <= 5'b00000;
      for (int i = 0; i < 5; i++) cnt_r[i] <= '0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      for (int i = 0; i < 5; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LIM) begin
          deb_r[i] <= ~deb_r[i];
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Fixed priority among simultaneous direction presses: up > down > left > right.
  always_comb begin
    press_dir_s = CODE_HOLD;
    if (press_s[0])      press_dir_s = DIR_UP;
    else if (press_s[1]) press_dir_s = DIR_DOWN;
    else if (press_s[2]) press_dir_s = DIR_LEFT;
    else if (press_s[3]) press_dir_s = DIR_RIGHT;
    else                 press_dir_s = CODE_HOLD;
  end

  // Decide whether the pending request replaces the current direction at the boundary.
  always_comb begin
`ifdef REVERSE_LOCK_EN
    apply_s = pend_vld_r && (pend_dir_r != opposite_dir(cur_dir_r));
`else
    apply_s = pend_vld_r;
`endif
    if (apply_s) next_dir_s = pend_dir_r;
    else         next_dir_s = cur_dir_r;
  end

  // Pending request: a press in the boundary cycle survives into the next frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_vld_r <= 1'b0;
      pend_dir_r <= CODE_HOLD;
    end else if (dir_press_s) begin
      pend_vld_r <= 1'b1;
      pend_dir_r <= press_dir_s;
    end else if (bnd_s) begin
      pend_vld_r <= 1'b0;
      pend_dir_r <= CODE_HOLD;
    end else begin
      pend_vld_r <= pend_vld_r;
      pend_dir_r <= pend_dir_r;
    end
  end

  // Game-state FSM; crash bypasses frame alignment and wins over a same-cycle boundary.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      start_req_r <= 1'b0;
      cur_dir_r   <= DIR_RIGHT;
      p1_info_r   <= CODE_HOLD;
      dflt_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bnd_s && start_req_r) begin
            state_r     <= ST_RUN;
            start_req_r <= 1'b0;
            cur_dir_r   <= DIR_RIGHT;
            p1_info_r   <= DIR_RIGHT;
            dflt_r      <= 1'b0;
          end else if (start_press_s) begin
            start_req_r <= 1'b1;
          end else begin
            start_req_r <= start_req_r;
          end
        end
        ST_RUN: begin
          if (bus.crash) begin
            state_r   <= ST_STOPPED;
            p1_info_r <= CODE_STOP;
          end else if (bnd_s) begin
            cur_dir_r <= next_dir_s;
            p1_info_r <= next_dir_s;
          end else begin
            cur_dir_r <= cur_dir_r;
          end
        end
        ST_STOPPED: begin
          if (bnd_s && start_req_r) begin
            state_r     <= ST_IDLE;
            start_req_r <= 1'b0;
            cur_dir_r   <= DIR_RIGHT;
            p1_info_r   <= CODE_HOLD;
            dflt_r      <= 1'b1;
          end else if (start_press_s) begin
            start_req_r <= 1'b1;
          end else begin
            start_req_r <= start_req_r;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          start_req_r <= 1'b0;
          cur_dir_r   <= DIR_RIGHT;
          p1_info_r   <= CODE_HOLD;
          dflt_r      <= 1'b1;
        end
      endcase
    end
  end

  // Frame-boundary pulse, one cycle after the boundary pixel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) frame_tick_r <= 1'b0;
    else        frame_tick_r <= bnd_s;
  end

  assign bus.p1_info    = p1_info_r;
  assign bus.dflt       = dflt_r;
  assign bus.frame_tick = frame_tick_r;
endmodule

// File: tb/tb_p1_dir_ctrl.sv
// Directed bench for p1_dir_ctrl with a shortened debounce window.
module tb_p1_dir_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  p1_dir_ctrl_if bus_i ();

  p1_dir_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .FRAME_ROW(599),
    .FRAME_COL(799)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus_i)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic bnd_on();
    bus_i.row = 10'd599;
    bus_i.col = 10'd799;
  endtask

  task automatic bnd_off();
    bus_i.row = 10'd100;
    bus_i.col = 10'd200;
  endtask

  task automatic frame_edge();
    bnd_on();
    tick(1);
    bnd_off();
  endtask

  initial begin
    bnd_off();
    bus_i.btn_up = 1'b0; bus_i.btn_down = 1'b0; bus_i.btn_left = 1'b0;
    bus_i.btn_right = 1'b0; bus_i.btn_start = 1'b0; bus_i.crash = 1'b0;

    // reset state
    tick(3);
    check("rst_info", bus_i.p1_info, 4'b0000);
    check("rst_dflt", {3'b000, bus_i.dflt}, 4'b0001);
    check("rst_tick", {3'b000, bus_i.frame_tick}, 4'b0000);
    reset = 1'b1;
    tick(2);

    // crash in IDLE is ignored
    bus_i.crash = 1'b1; tick(1); bus_i.crash = 1'b0; tick(1);
    check("idle_crash_info", bus_i.p1_info, 4'b0000);
    check("idle_crash_dflt", {3'b000, bus_i.dflt}, 4'b0001);

    // start press, then boundary -> RUN heading right
    bus_i.btn_start = 1'b1; tick(12); bus_i.btn_start = 1'b0; tick(12);
    check("start_wait_dflt", {3'b000, bus_i.dflt}, 4'b0001);
    check("start_wait_info", bus_i.p1_info, 4'b0000);
    bnd_on(); #1;
    check("bnd_cycle_dflt", {3'b000, bus_i.dflt}, 4'b0001);
    tick(1); bnd_off();
    check("run_tick", {3'b000, bus_i.frame_tick}, 4'b0001);
    check("run_dflt", {3'b000, bus_i.dflt}, 4'b0000);
    check("run_info", bus_i.p1_info, 4'b1000);
    tick(1);
    check("tick_low", {3'b000, bus_i.frame_tick}, 4'b0000);

    // up press mid-frame waits for the boundary
    bus_i.btn_up = 1'b1; tick(12); bus_i.btn_up = 1'b0; tick(12);
    check("up_mid", bus_i.p1_info, 4'b1000);
    frame_edge();
    check("up_bnd", bus_i.p1_info, 4'b0001);

    // too-short down pulse is rejected
    bus_i.btn_down = 1'b1; tick(2); bus_i.btn_down = 1'b0; tick(10);
    frame_edge();
    check("short_down", bus_i.p1_info, 4'b0001);

    // right press, then left reversal
    bus_i.btn_right = 1'b1; tick(12); bus_i.btn_right = 1'b0; tick(12);
    frame_edge();
    check("right_bnd", bus_i.p1_info, 4'b1000);
    bus_i.btn_left = 1'b1; tick(12); bus_i.btn_left = 1'b0; tick(12);
    frame_edge();
`ifdef REVERSE_LOCK_EN
    check("left_rev", bus_i.p1_info, 4'b1000);
`else
    check("left_rev", bus_i.p1_info, 4'b0100);
`endif
    // pending consumed: an empty frame keeps the code
    tick(5);
    frame_edge();
`ifdef REVERSE_LOCK_EN
    check("empty_frame", bus_i.p1_info, 4'b1000);
`else
    check("empty_frame", bus_i.p1_info, 4'b0100);
`endif

    // one-cycle crash mid-frame stops immediately
    tick(3);
    bus_i.crash = 1'b1; tick(1); bus_i.crash = 1'b0;
    check("crash_info", bus_i.p1_info, 4'b1001);
    check("crash_dflt", {3'b000, bus_i.dflt}, 4'b0000);
    frame_edge();
    check("stopped_no_start", bus_i.p1_info, 4'b1001);
    bus_i.btn_start = 1'b1; tick(12); bus_i.btn_start = 1'b0; tick(12);
    frame_edge();
    check("restart_info", bus_i.p1_info, 4'b0000);
    check("restart_dflt", {3'b000, bus_i.dflt}, 4'b0001);

    // back to RUN, then simultaneous up+right
    bus_i.btn_start = 1'b1; tick(12); bus_i.btn_start = 1'b0; tick(12);
    frame_edge();
    check("rerun_info", bus_i.p1_info, 4'b1000);
    bus_i.btn_up = 1'b1; bus_i.btn_right = 1'b1; tick(12);
    bus_i.btn_up = 1'b0; bus_i.btn_right = 1'b0; tick(12);
    frame_edge();
    check("prio_up", bus_i.p1_info, 4'b0001);

    // crash beats a same-cycle boundary update
    bus_i.btn_left = 1'b1; tick(12); bus_i.btn_left = 1'b0; tick(12);
    bnd_on(); bus_i.crash = 1'b1; tick(1); bnd_off(); bus_i.crash = 1'b0;
    check("crash_vs_bnd", bus_i.p1_info, 4'b1001);

    // asynchronous reset mid-frame
    #2; reset = 1'b0; #1;
    check("async_rst_info", bus_i.p1_info, 4'b0000);
    check("async_rst_dflt", {3'b000, bus_i.dflt}, 4'b0001);
    tick(2);
    reset = 1'b1;
    tick(2);
    frame_edge();
    check("post_rst_idle", bus_i.p1_info, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/p1_dir_ctrl.md
Name: p1_dir_ctrl

Overview:
- Upstream input stage for draw_object. Synchronises and debounces the player-1 buttons and runs the game-state FSM.
- Drives the 4-bit p1_info direction code and the dflt start-position strobe.
- Updates p1_info only at the frame boundary, so the movement logic samples a stable code once per frame.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a button level change (5 ms at 50 MHz).
- CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- FRAME_ROW, 599, row of the frame-boundary pixel.
- FRAME_COL, 799, col of the frame-boundary pixel.

Ports:
- clock  in  1  system pixel clock
- reset  in  1  asynchronous, active-low reset
- row  in  10  current scan row
- col  in  10  current scan column
- btn_up  in  1  raw button, active-high, asynchronous to clock
- btn_down  in  1  raw button
- btn_left  in  1  raw button
- btn_right  in  1  raw button
- btn_start  in  1  raw button
- crash  in  1  collision flag from the collision stage, sampled on any cycle
- p1_info  out  4  direction code to draw_object
- dflt  out  1  high forces the player to the start position
- frame_tick  out  1  registered one-cycle pulse, one cycle after row==FRAME_ROW && col==FRAME_COL

Behaviour:
- Encoding of p1_info:
  - 0001 up, 0010 down, 0100 left, 1000 right, 1001 stop, 0000 hold.
  - No other values are ever driven.
- Reset (reset low, asynchronous assert, synchronous deassert of internal logic):
  - p1_info=0000, dflt=1, frame_tick=0.
  - FSM in IDLE, cur_dir=right, pending empty.
  - All synchroniser and debounce state is 0.
- Input conditioning:
  - Each button passes through a 2-flop synchroniser, then its own debounce counter.
  - The counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A rising edge of a debounced level produces a one-cycle internal press pulse.
- Pending request register:
  - A direction press loads pending; the latest press overwrites any earlier one.
  - Simultaneous direction presses resolve by priority: up > down > left > right.
  - Pending clears at every boundary cycle (bnd = row==FRAME_ROW && col==FRAME_COL), whether or not it was applied.
  - A press arriving in the bnd cycle itself is kept for the next frame.
- FSM states:
  - IDLE:
    - dflt=1, p1_info=0000.
    - A start press sets start_req.
    - At bnd with start_req set: go to RUN, clear start_req, cur_dir=right.
  - RUN:
    - dflt=0.
    - At bnd: if pending is valid and not the reverse of cur_dir, cur_dir=pending.
    - At the same edge, p1_info is loaded with the code for the resulting cur_dir.
    - crash=1 on any cycle: go to STOPPED next cycle and set p1_info=1001 immediately on that edge (not frame-aligned).
  - STOPPED:
    - p1_info=1001, dflt=0.
    - A start press sets start_req.
    - At bnd with start_req set: go to IDLE and set p1_info=0000.
- Latency:
  - p1_info changes only on the clock edge that ends the bnd cycle; the crash-to-stop path is the one exception.
  - draw_object therefore applies a direction one frame after it is latched (intended).
- dflt timing:
  - dflt is still 1 during the bnd cycle in which IDLE->RUN occurs, so draw_object loads the start position.
  - dflt is 0 from the next cycle.
- Simultaneous events:
  - crash has priority over any bnd update in the same cycle.
  - A start press while in RUN is ignored.
  - A crash while in IDLE or STOPPED is ignored.
- Reset mid-frame:
  - Returns to the reset values immediately.
  - Any pending press is lost.

Optional Feature:
- Macro: REVERSE_LOCK_EN.
- Defined: a pending direction that is the 180-degree opposite of cur_dir is discarded at bnd and cur_dir is unchanged.
  - Opposite pairs: up/down, left/right.
- Undefined: any pending direction is applied, including reversals.

Test Plan:
- Reset, then btn_start held 6 ms, then frame boundary reached -> dflt=1 through the bnd cycle; afterwards dflt=0 and p1_info=1000.
- In RUN, btn_up pressed mid-frame -> p1_info stays 1000 until the edge after row=599/col=799, then becomes 0001.
- btn_down pulse of 1 ms (shorter than DEBOUNCE_CYCLES) -> no change to p1_info.
- In RUN with cur_dir=right, btn_left pressed, REVERSE_LOCK_EN defined -> p1_info stays 1000; with the macro undefined -> p1_info becomes 0100.
- crash=1 for one cycle mid-frame -> p1_info=1001 on the next edge; later btn_start press plus bnd -> p1_info=0000 and dflt=1.
- btn_up and btn_right debounced in the same cycle -> at bnd p1_info=0001; asserting reset low mid-frame -> p1_info=0000 and dflt=1 asynchronously.
